// File: rtl/entry_sequencer.sv
// entry_sequencer: debounced two-button digit entry, verify handshake and verdict hold
module entry_sequencer #(
  parameter int NUM_DIGITS      = 4,
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int TIMEOUT_CYCLES  = 50000000,
  parameter int VERIFY_LATENCY  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       btn1,
  input  logic       btn2,
  input  logic       final_analysis,
  output logic       shift_en,
  output logic       shift_bit,
  output logic       waiting_for_user,
  output logic       start_verification,
  output logic [3:0] digit_count,
  output logic       result_valid,
  output logic       result,
  output logic       timeout
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int VW = $clog2(VERIFY_LATENCY + 1);
  typedef enum logic [2:0] {IDLE, WAIT_PRESS, WAIT_RELEASE, VERIFY, RESULT} state_t;
  state_t state, state_n;
  logic [1:0] sync1, sync2;
  logic [DW-1:0] deb, deb_n;
  logic [TW-1:0] tmo, tmo_n;
  logic [VW-1:0] vcnt, vcnt_n;
  logic [3:0] count_n;
  logic last, last_n, qual, same, deb_done;
  logic shift_en_n, shift_bit_n, wait_n, start_ver_n, valid_n, result_n, timeout_n;
  always_comb begin
    qual = sync2[1] ^ sync2[0];
    same = (deb == '0) || (sync2[1] == last);
    deb_done = deb == DW'(DEBOUNCE_CYCLES - 1);
    state_n = state;
    deb_n = deb;
    tmo_n = tmo;
    vcnt_n = vcnt;
    last_n = last;
    count_n = digit_count;
    shift_en_n = 1'b0;
    shift_bit_n = shift_bit;
    start_ver_n = 1'b0;
    valid_n = result_valid;
    result_n = result;
    timeout_n = timeout;
    case (state)
      IDLE: begin
        deb_n = '0;
        tmo_n = '0;
        count_n = '0;
        state_n = start ? WAIT_PRESS : IDLE;
      end
      WAIT_PRESS: begin
        last_n = qual ? sync2[1] : last;
        if (qual && same && deb_done) begin
          shift_en_n = 1'b1;
          shift_bit_n = sync2[1];
          count_n = digit_count + 4'd1;
          deb_n = '0;
          tmo_n = '0;
          state_n = WAIT_RELEASE;
        end else begin
          deb_n = !qual ? '0 : same ? deb + 1'b1 : DW'(1);
          tmo_n = tmo + 1'b1;
          if (tmo == TW'(TIMEOUT_CYCLES - 1)) begin
            deb_n = '0;
            valid_n = 1'b1;
            result_n = 1'b0;
            timeout_n = 1'b1;
            state_n = RESULT;
          end
        end
      end
      WAIT_RELEASE: begin
        deb_n = (sync2 == 2'b00) ? deb + 1'b1 : '0;
        if (sync2 == 2'b00 && deb_done) begin
          deb_n = '0;
          vcnt_n = '0;
          start_ver_n = digit_count == 4'(NUM_DIGITS);
          state_n = (digit_count == 4'(NUM_DIGITS)) ? VERIFY : WAIT_PRESS;
        end
      end
      VERIFY: begin
        vcnt_n = vcnt + 1'b1;
        if (vcnt == VW'(VERIFY_LATENCY)) begin
          valid_n = 1'b1;
          result_n = final_analysis;
          timeout_n = 1'b0;
          state_n = RESULT;
        end
      end
      RESULT: begin
        if (start) begin
          valid_n = 1'b0;
          result_n = 1'b0;
          timeout_n = 1'b0;
          count_n = '0;
          deb_n = '0;
          tmo_n = '0;
          state_n = WAIT_PRESS;
        end
      end
      default: state_n = IDLE;
    endcase
    wait_n = (state_n == WAIT_PRESS) || (state_n == WAIT_RELEASE);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sync1 <= '0;
      sync2 <= '0;
      deb <= '0;
      tmo <= '0;
      vcnt <= '0;
      last <= 1'b0;
      shift_en <= 1'b0;
      shift_bit <= 1'b0;
      waiting_for_user <= 1'b0;
      start_verification <= 1'b0;
      digit_count <= '0;
      result_valid <= 1'b0;
      result <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state <= state_n;
      sync1 <= {btn1, btn2};
      sync2 <= sync1;
      deb <= deb_n;
      tmo <= tmo_n;
      vcnt <= vcnt_n;
      last <= last_n;
      shift_en <= shift_en_n;
      shift_bit <= shift_bit_n;
      waiting_for_user <= wait_n;
      start_verification <= start_ver_n;
      digit_count <= count_n;
      result_valid <= valid_n;
      result <= result_n;
      timeout <= timeout_n;
    end
  end
endmodule

// File: tb/tb_entry_sequencer.sv
// tb_entry_sequencer: directed and randomized checks against a history-window reference model
module tb_entry_sequencer;
  localparam int N = 4;
  localparam int D = 4;
  localparam int T = 100;
  localparam int L = 2;
  localparam int MAXE = 8192;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic btn1 = 1'b0;
  logic btn2 = 1'b0;
  logic fa = 1'b0;
  logic shift_en, shift_bit, waiting_for_user, start_verification, result_valid, result, timeout;
  logic [3:0] digit_count;
  int passed = 0;
  int total = 0;
  int fails = 0;
  int se_cnt = 0;
  int sv_cnt = 0;
  int t = 0;
  int rst_edge = -1000;
  int ph = 0;
  int entry = 0;
  int ventry = 0;
  logic [1:0] raw_a [0:MAXE-1];
  logic e_se = 0, e_sb = 0, e_sv = 0, e_rv = 0, e_res = 0, e_to = 0;
  logic [3:0] e_dc = 0;

  entry_sequencer #(.NUM_DIGITS(N), .DEBOUNCE_CYCLES(D), .TIMEOUT_CYCLES(T), .VERIFY_LATENCY(L)) dut (
    .clk(clk), .rst(rst), .start(start), .btn1(btn1), .btn2(btn2), .final_analysis(fa),
    .shift_en(shift_en), .shift_bit(shift_bit), .waiting_for_user(waiting_for_user),
    .start_verification(start_verification), .digit_count(digit_count),
    .result_valid(result_valid), .result(result), .timeout(timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] syn(int e);
    return (e - 2 > rst_edge && e - 2 >= 0) ? raw_a[e-2] : 2'b00;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_update();
    logic [1:0] s;
    bit ok;
    if (t < MAXE) raw_a[t] = {btn1, btn2};
    if (rst) begin
      ph = 0; rst_edge = t;
      e_se = 0; e_sb = 0; e_sv = 0; e_rv = 0; e_res = 0; e_to = 0; e_dc = 0;
    end else begin
      e_se = 0;
      e_sv = 0;
      case (ph)
        0: if (start) begin ph = 1; entry = t; end
        1: begin
          s = syn(t);
          ok = (s == 2'b10 || s == 2'b01) && (t - D + 1 > entry);
          for (int k = 1; k < D; k++) ok = ok && (syn(t - k) == s);
          if (ok) begin
            e_se = 1; e_sb = s[1]; e_dc = e_dc + 1; ph = 2; entry = t;
          end else if (t - entry == T) begin
            ph = 4; e_rv = 1; e_res = 0; e_to = 1;
          end
        end
        2: begin
          ok = t - D + 1 > entry;
          for (int k = 0; k < D; k++) ok = ok && (syn(t - k) == 2'b00);
          if (ok && e_dc == N) begin
            ph = 3; e_sv = 1; ventry = t;
          end else if (ok) begin
            ph = 1; entry = t;
          end
        end
        3: if (t - ventry == L + 1) begin
          e_res = fa; e_rv = 1; e_to = 0; ph = 4;
        end
        default: if (start) begin
          e_rv = 0; e_res = 0; e_to = 0; e_dc = 0; ph = 1; entry = t;
        end
      endcase
    end
    t++;
  endtask

  task automatic check_all();
    chk("shift_en", shift_en, e_se);
    if (e_se) chk("shift_bit", shift_bit, e_sb);
    chk("start_verification", start_verification, e_sv);
    chk("waiting_for_user", waiting_for_user, ph == 1 || ph == 2);
    chk("digit_count", digit_count, e_dc);
    chk("result_valid", result_valid, e_rv);
    chk("result", result, e_res);
    chk("timeout", timeout, e_to);
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check_all();
    if (shift_en) se_cnt++;
    if (start_verification) sv_cnt++;
  endtask

  task automatic press(input logic [1:0] b, input int hold, input int gap, output int lat, output logic sb);
    {btn1, btn2} = b;
    lat = 0;
    sb = 1'bx;
    for (int i = 1; i <= hold; i++) begin
      step();
      if (shift_en && lat == 0) begin lat = i; sb = shift_bit; end
    end
    {btn1, btn2} = 2'b00;
    repeat (gap) step();
  endtask

  task automatic start_pulse();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    int lat, n, se0, sv0;
    logic sb;
    logic [1:0] pat [4];
    logic [1:0] b;
    pat[0] = 2'b10; pat[1] = 2'b01; pat[2] = 2'b10; pat[3] = 2'b10;
    step();
    step();
    chk("rst_digit_count", digit_count, 0);
    chk("rst_result_valid", result_valid, 0);
    rst = 1'b0;
    step();
    fa = 1'b1;
    start_pulse();
    se0 = se_cnt; sv0 = sv_cnt;
    for (int d = 0; d < 4; d++) begin
      press(pat[d], 10, 10, lat, sb);
      chk("normal_latency", lat, 6);
      chk("normal_bit", sb, pat[d][1]);
    end
    chk("normal_shifts", se_cnt - se0, 4);
    chk("normal_verify_pulses", sv_cnt - sv0, 1);
    chk("normal_result_valid", result_valid, 1);
    chk("normal_result", result, 1);
    chk("normal_timeout", timeout, 0);
    chk("normal_digit_count", digit_count, 4);
    start_pulse();
    se0 = se_cnt;
    for (int i = 0; i < 5; i++) begin
      btn2 = 1'b1; repeat (2) step();
      btn2 = 1'b0; repeat (2) step();
    end
    chk("bounce_no_early_shift", se_cnt - se0, 0);
    press(2'b01, 10, 10, lat, sb);
    chk("bounce_latency", lat, 6);
    chk("bounce_bit", sb, 0);
    chk("bounce_shifts", se_cnt - se0, 1);
    chk("bounce_digit_count", digit_count, 1);
    se0 = se_cnt;
    {btn1, btn2} = 2'b11;
    repeat (20) step();
    chk("both_no_shift", se_cnt - se0, 0);
    press(2'b10, 30, 10, lat, sb);
    chk("held_latency", lat, 6);
    chk("held_bit", sb, 1);
    chk("held_single_shift", se_cnt - se0, 1);
    chk("held_digit_count", digit_count, 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_digit_count", digit_count, 0);
    chk("midrst_waiting", waiting_for_user, 0);
    chk("midrst_shift_en", shift_en, 0);
    step();
    fa = 1'b0;
    start_pulse();
    se0 = se_cnt; sv0 = sv_cnt;
    for (int d = 0; d < 4; d++) press(pat[3-d], 10, 10, lat, sb);
    chk("postrst_shifts", se_cnt - se0, 4);
    chk("postrst_verify_pulses", sv_cnt - sv0, 1);
    chk("postrst_result_valid", result_valid, 1);
    chk("postrst_result", result, 0);
    start_pulse();
    sv0 = sv_cnt;
    n = 0;
    for (int i = 1; i <= T; i++) begin
      step();
      if (result_valid && n == 0) n = i;
    end
    chk("timeout_cycles", n, T);
    chk("timeout_flag", timeout, 1);
    chk("timeout_result", result, 0);
    chk("timeout_no_verify", sv_cnt - sv0, 0);
    start_pulse();
    chk("restart_result_valid", result_valid, 0);
    chk("restart_timeout", timeout, 0);
    chk("restart_waiting", waiting_for_user, 1);
    for (int s = 0; s < 8; s++) begin
      rst = 1'b1; step(); rst = 1'b0; step();
      fa = 1'($urandom_range(0, 1));
      start_pulse();
      for (int d = 0; d < 4; d++) begin
        b = $urandom_range(0, 1) ? 2'b10 : 2'b01;
        for (int k = $urandom_range(0, 2); k > 0; k--) begin
          start = 1'($urandom_range(0, 1));
          {btn1, btn2} = b; repeat ($urandom_range(1, 3)) step();
          {btn1, btn2} = 2'b00; repeat ($urandom_range(1, 3)) step();
        end
        start = 1'b0;
        press(b, $urandom_range(7, 14), $urandom_range(7, 12), lat, sb);
        chk("rand_bit", sb, b[1]);
      end
      repeat (8) step();
      chk("rand_result_valid", result_valid, 1);
      chk("rand_result", result, fa);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
